// File: rtl/mips_mem_pkg.sv
// Shared definitions for the MEM-stage access unit: access sizes, FSM encoding,
// big-endian byte-lane constants and the load extension helper.
package mips_mem_pkg;

   localparam logic [1:0] MEM_SIZE_BYTE = 2'b00;
   localparam logic [1:0] MEM_SIZE_HALF = 2'b01;
   localparam logic [1:0] MEM_SIZE_WORD = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_DONE = 2'd2
   } acc_state_e;

   // Lane 0 is the most significant byte; enables shift right as the offset grows.
   localparam logic [3:0] BE_BYTE_LANE0 = 4'b1000;
   localparam logic [3:0] BE_HALF_LANE0 = 4'b1100;
   localparam logic [3:0] BE_WORD_ALL   = 4'b1111;

   function automatic logic [31:0] extend_field(input logic [15:0] field,
                                                input logic        is_half,
                                                input logic        signe);
      logic fill;
      if (is_half) begin
         fill = signe & field[15];
         return {{16{fill}}, field};
      end else begin
         fill = signe & field[7];
         return {{24{fill}}, field[7:0]};
      end
   endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane steering: store-data replication and byte enables, plus load
// lane extraction with sign/zero extension. Misaligned offsets are aligned down.
module mem_lane_align
   import mips_mem_pkg::*;
(
   input  logic [1:0]  size_i,
   input  logic        signe_i,
   input  logic [1:0]  off_i,
   input  logic [31:0] wdata_i,
   input  logic [31:0] rdata_i,
   output logic [3:0]  be_o,
   output logic [31:0] wdata_o,
   output logic [31:0] load_o
);

   logic [7:0]  byte_s;
   logic [15:0] half_s;

   // Lane selection per access size; reserved size falls through to word.
   always_comb begin
      be_o    = BE_WORD_ALL;
      wdata_o = wdata_i;
      load_o  = rdata_i;
      byte_s  = 8'h00;
      half_s  = 16'h0000;
      case (size_i)
         MEM_SIZE_BYTE: begin
            be_o    = BE_BYTE_LANE0 >> off_i;
            wdata_o = {4{wdata_i[7:0]}};
            case (off_i)
               2'd0:    byte_s = rdata_i[31:24];
               2'd1:    byte_s = rdata_i[23:16];
               2'd2:    byte_s = rdata_i[15:8];
               default: byte_s = rdata_i[7:0];
            endcase
            load_o  = extend_field({8'h00, byte_s}, 1'b0, signe_i);
         end
         MEM_SIZE_HALF: begin
            be_o    = BE_HALF_LANE0 >> {off_i[1], 1'b0};
            wdata_o = {2{wdata_i[15:0]}};
            if (off_i[1]) begin
               half_s = rdata_i[15:0];
            end else begin
               half_s = rdata_i[31:16];
            end
            load_o  = extend_field(half_s, 1'b1, signe_i);
         end
         default: begin
            be_o    = BE_WORD_ALL;
            wdata_o = wdata_i;
            load_o  = rdata_i;
         end
      endcase
   end

endmodule

// File: rtl/mem_stage_access_unit.sv
// MEM-stage controller: runs one req/ack data-bus transaction per memory instruction and
// stalls the pipeline meanwhile. Define MEM_MISALIGN_TRAP_EN to trap misaligned half/word.
module mem_stage_access_unit
   import mips_mem_pkg::*;
#(
   parameter int unsigned ADDR_W      = 9,
   parameter int unsigned TIMEOUT_CYC = 15
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              MEM_ENABLE,
   input  logic              MEM_READWRITE,
   input  logic [1:0]        MEM_SIZE,
   input  logic              MEM_SIGNE,
   input  logic [ADDR_W-1:0] MEM_ADDRESS,
   input  logic [31:0]       MEM_WDATA,
   input  logic              BUS_ACK,
   input  logic [31:0]       BUS_RDATA,
   output logic              BUS_REQ,
   output logic              BUS_WE,
   output logic [ADDR_W-1:0] BUS_ADDR,
   output logic [3:0]        BUS_BE,
   output logic [31:0]       BUS_WDATA,
   output logic              MEM_STALL,
   output logic [31:0]       LOAD_DATA,
   output logic              ACC_DONE,
   output logic              BUS_ERR,
   output logic              ADDR_ERR
);

   localparam int unsigned CNT_W = (TIMEOUT_CYC == 0) ? 1 : $clog2(TIMEOUT_CYC + 1);
   // Counter value seen on the last permitted WAIT cycle.
   localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT_CYC == 0) ? '0 : CNT_W'(TIMEOUT_CYC - 1);

   acc_state_e        state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [1:0]        size_q, size_d;
   logic              rw_q, rw_d;
   logic              signe_q, signe_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [31:0]       load_q, load_d;
   logic              bus_err_q, bus_err_d;
   logic              addr_err_q, addr_err_d;
   logic              stall_s;
   logic              misalign_s;
   logic              in_wait_s;
   logic [3:0]        be_s;
   logic [31:0]       wdata_s;
   logic [31:0]       load_fmt_s;

`ifdef MEM_MISALIGN_TRAP_EN
   always_comb begin
      misalign_s = 1'b0;
      case (MEM_SIZE)
         MEM_SIZE_BYTE: misalign_s = 1'b0;
         MEM_SIZE_HALF: misalign_s = MEM_ADDRESS[0];
         default:       misalign_s = (MEM_ADDRESS[1:0] != 2'b00);
      endcase
   end
`else
   assign misalign_s = 1'b0;
`endif

   mem_lane_align u_lane (
      .size_i  (size_q),
      .signe_i (signe_q),
      .off_i   (addr_q[1:0]),
      .wdata_i (wdata_q),
      .rdata_i (BUS_RDATA),
      .be_o    (be_s),
      .wdata_o (wdata_s),
      .load_o  (load_fmt_s)
   );

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q    <= ST_IDLE;
         addr_q     <= '0;
         wdata_q    <= 32'h0000_0000;
         size_q     <= 2'b00;
         rw_q       <= 1'b0;
         signe_q    <= 1'b0;
         cnt_q      <= '0;
         load_q     <= 32'h0000_0000;
         bus_err_q  <= 1'b0;
         addr_err_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         size_q     <= size_d;
         rw_q       <= rw_d;
         signe_q    <= signe_d;
         cnt_q      <= cnt_d;
         load_q     <= load_d;
         bus_err_q  <= bus_err_d;
         addr_err_q <= addr_err_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      size_d     = size_q;
      rw_d       = rw_q;
      signe_d    = signe_q;
      cnt_d      = cnt_q;
      load_d     = load_q;
      bus_err_d  = 1'b0;
      addr_err_d = 1'b0;
      stall_s    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (MEM_ENABLE) begin
               stall_s = 1'b1;
               addr_d  = MEM_ADDRESS;
               wdata_d = MEM_WDATA;
               size_d  = MEM_SIZE;
               rw_d    = MEM_READWRITE;
               signe_d = MEM_SIGNE;
               cnt_d   = '0;
               if (misalign_s) begin
                  state_d    = ST_DONE;
                  addr_err_d = 1'b1;
               end else begin
                  state_d = ST_WAIT;
               end
            end else begin
               stall_s = 1'b0;
            end
         end
         ST_WAIT: begin
            stall_s = 1'b1;
            // ACK takes priority over a timeout landing in the same cycle.
            if (BUS_ACK) begin
               state_d = ST_DONE;
               if (!rw_q) begin
                  load_d = load_fmt_s;
               end else begin
                  load_d = load_q;
               end
            end else if ((TIMEOUT_CYC != 0) && (cnt_q == CNT_LAST)) begin
               state_d   = ST_DONE;
               bus_err_d = 1'b1;
               if (!rw_q) begin
                  load_d = 32'h0000_0000;
               end else begin
                  load_d = load_q;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign in_wait_s = (state_q == ST_WAIT);
   assign BUS_REQ   = in_wait_s;
   assign BUS_WE    = in_wait_s & rw_q;
   assign BUS_ADDR  = in_wait_s ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
   assign BUS_BE    = in_wait_s ? be_s : 4'h0;
   assign BUS_WDATA = (in_wait_s && rw_q) ? wdata_s : 32'h0000_0000;
   assign MEM_STALL = stall_s;
   assign LOAD_DATA = load_q;
   assign ACC_DONE  = (state_q == ST_DONE);
   assign BUS_ERR   = bus_err_q;
   assign ADDR_ERR  = addr_err_q;

endmodule

// File: tb/tb_mem_stage_access_unit.sv
// Scoreboard bench for mem_stage_access_unit: stimulus queues expected bus requests and
// completions; a monitor pops and compares when BUS_REQ rises or ACC_DONE pulses.
`timescale 1ns/1ps
module tb_mem_stage_access_unit;

   typedef struct packed {
      logic        we;
      logic [8:0]  addr;
      logic [3:0]  be;
      logic [31:0] wdata;
   } bus_exp_t;

   typedef struct packed {
      logic [31:0] load;
      logic        berr;
      logic        aerr;
      logic [7:0]  req_cycles;
   } done_exp_t;

   logic        Clk = 1'b0;
   logic        Reset = 1'b0;
   logic        MEM_ENABLE = 1'b0;
   logic        MEM_READWRITE = 1'b0;
   logic [1:0]  MEM_SIZE = 2'b00;
   logic        MEM_SIGNE = 1'b0;
   logic [8:0]  MEM_ADDRESS = 9'h000;
   logic [31:0] MEM_WDATA = 32'h0;
   logic        BUS_ACK = 1'b0;
   logic [31:0] BUS_RDATA = 32'h0;
   logic        BUS_REQ, BUS_WE, MEM_STALL, ACC_DONE, BUS_ERR, ADDR_ERR;
   logic [8:0]  BUS_ADDR;
   logic [3:0]  BUS_BE;
   logic [31:0] BUS_WDATA, LOAD_DATA;

   bus_exp_t  bus_q[$];
   done_exp_t done_q[$];
   int errors = 0;
   int checks = 0;
   int done_count = 0;

   mem_stage_access_unit #(.ADDR_W(9), .TIMEOUT_CYC(15)) dut (
      .Clk(Clk), .Reset(Reset), .MEM_ENABLE(MEM_ENABLE), .MEM_READWRITE(MEM_READWRITE),
      .MEM_SIZE(MEM_SIZE), .MEM_SIGNE(MEM_SIGNE), .MEM_ADDRESS(MEM_ADDRESS),
      .MEM_WDATA(MEM_WDATA), .BUS_ACK(BUS_ACK), .BUS_RDATA(BUS_RDATA),
      .BUS_REQ(BUS_REQ), .BUS_WE(BUS_WE), .BUS_ADDR(BUS_ADDR), .BUS_BE(BUS_BE),
      .BUS_WDATA(BUS_WDATA), .MEM_STALL(MEM_STALL), .LOAD_DATA(LOAD_DATA),
      .ACC_DONE(ACC_DONE), .BUS_ERR(BUS_ERR), .ADDR_ERR(ADDR_ERR)
   );

   always #5 Clk = ~Clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: pops expectations when a request opens or an access completes.
   initial begin : monitor
      logic      prev_req;
      int        req_cnt;
      bus_exp_t  bx;
      done_exp_t dx;
      prev_req = 1'b0;
      req_cnt  = 0;
      forever begin
         @(negedge Clk);
         if (Reset) begin
            prev_req = 1'b0;
            req_cnt  = 0;
         end else begin
            if (BUS_REQ) begin
               req_cnt++;
               check("stall_in_wait", 32'(MEM_STALL), 32'd1);
               if (!prev_req) begin
                  checks++;
                  if (bus_q.size() == 0) begin
                     errors++;
                     $display("FAIL unexpected_req: BUS_REQ rose with nothing queued at %0t", $time);
                  end else begin
                     bx = bus_q.pop_front();
                     check("bus_we", 32'(BUS_WE), 32'(bx.we));
                     check("bus_addr", 32'(BUS_ADDR), 32'(bx.addr));
                     check("bus_be", 32'(BUS_BE), 32'(bx.be));
                     check("bus_wdata", BUS_WDATA, bx.wdata);
                  end
               end
            end
            prev_req = BUS_REQ;
            if (ACC_DONE) begin
               done_count++;
               checks++;
               if (done_q.size() == 0) begin
                  errors++;
                  $display("FAIL unexpected_done: ACC_DONE with nothing queued at %0t", $time);
               end else begin
                  dx = done_q.pop_front();
                  check("load_data", LOAD_DATA, dx.load);
                  check("bus_err", 32'(BUS_ERR), 32'(dx.berr));
                  check("addr_err", 32'(ADDR_ERR), 32'(dx.aerr));
                  check("req_cycles", req_cnt, 32'(dx.req_cycles));
                  check("stall_in_done", 32'(MEM_STALL), 32'd0);
               end
               req_cnt = 0;
            end
         end
      end
   end

   // ack_delay < 0 means the bus never answers.
   task automatic access(input logic rw, input logic [1:0] size, input logic signe,
                         input logic [8:0] addr, input logic [31:0] wdata,
                         input int ack_delay, input logic [31:0] rdata,
                         input logic bus_expected, input bus_exp_t bexp, input done_exp_t dexp);
      bit seen;
      if (bus_expected) bus_q.push_back(bexp);
      done_q.push_back(dexp);
      @(negedge Clk);
      MEM_ENABLE    = 1'b1;
      MEM_READWRITE = rw;
      MEM_SIZE      = size;
      MEM_SIGNE     = signe;
      MEM_ADDRESS   = addr;
      MEM_WDATA     = wdata;
      #1 check("stall_idle", 32'(MEM_STALL), 32'd1);
      @(posedge Clk);
      #1 MEM_ENABLE = 1'b0;
      if (ack_delay >= 0) begin
         repeat (ack_delay) @(posedge Clk);
         @(negedge Clk);
         BUS_ACK   = 1'b1;
         BUS_RDATA = rdata;
         @(posedge Clk);
         #1 BUS_ACK = 1'b0;
         BUS_RDATA  = 32'h0;
      end
      seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge Clk);
         if (ACC_DONE) seen = 1'b1;
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL acc_done_wait: no ACC_DONE within 40 cycles at %0t", $time);
      end
      @(posedge Clk);
      #1;
   endtask

   initial begin : stimulus
      int done_before;
      #1 Reset = 1'b1;
      repeat (3) @(negedge Clk);
      check("rst_req", 32'(BUS_REQ), 32'd0);
      check("rst_stall", 32'(MEM_STALL), 32'd0);
      check("rst_done", 32'(ACC_DONE), 32'd0);
      check("rst_errs", {30'd0, BUS_ERR, ADDR_ERR}, 32'd0);
      check("rst_load", LOAD_DATA, 32'h0);
      check("rst_bus", {19'd0, BUS_WE, BUS_ADDR, BUS_BE} | BUS_WDATA, 32'h0);
      #1 Reset = 1'b0;

      // LB 0x003 signed, 2 wait states
      access(1'b0, 2'b00, 1'b1, 9'h003, 32'h0, 2, 32'h1122_3380, 1'b1,
             '{we:1'b0, addr:9'h000, be:4'b0001, wdata:32'h0},
             '{load:32'hFFFF_FF80, berr:1'b0, aerr:1'b0, req_cycles:8'd3});
      // LHU 0x006
      access(1'b0, 2'b01, 1'b0, 9'h006, 32'h0, 0, 32'hAAAA_8001, 1'b1,
             '{we:1'b0, addr:9'h004, be:4'b0011, wdata:32'h0},
             '{load:32'h0000_8001, berr:1'b0, aerr:1'b0, req_cycles:8'd1});
      // SB 0x001: LOAD_DATA must keep the previous load result
      access(1'b1, 2'b00, 1'b0, 9'h001, 32'h0000_00A5, 1, 32'hFFFF_FFFF, 1'b1,
             '{we:1'b1, addr:9'h000, be:4'b0100, wdata:32'hA5A5_A5A5},
             '{load:32'h0000_8001, berr:1'b0, aerr:1'b0, req_cycles:8'd2});
      // LW with no ACK: 15 request cycles then bus error
      access(1'b0, 2'b10, 1'b0, 9'h004, 32'h0, -1, 32'h0, 1'b1,
             '{we:1'b0, addr:9'h004, be:4'b1111, wdata:32'h0},
             '{load:32'h0, berr:1'b1, aerr:1'b0, req_cycles:8'd15});
      // LW 0x008
      access(1'b0, 2'b10, 1'b0, 9'h008, 32'h0, 0, 32'hDEAD_BEEF, 1'b1,
             '{we:1'b0, addr:9'h008, be:4'b1111, wdata:32'h0},
             '{load:32'hDEAD_BEEF, berr:1'b0, aerr:1'b0, req_cycles:8'd1});
`ifdef MEM_MISALIGN_TRAP_EN
      access(1'b0, 2'b10, 1'b0, 9'h002, 32'h0, -1, 32'h0, 1'b0,
             '{we:1'b0, addr:9'h000, be:4'b0000, wdata:32'h0},
             '{load:32'hDEAD_BEEF, berr:1'b0, aerr:1'b1, req_cycles:8'd0});
`else
      access(1'b0, 2'b10, 1'b0, 9'h002, 32'h0, 0, 32'h1234_5678, 1'b1,
             '{we:1'b0, addr:9'h000, be:4'b1111, wdata:32'h0},
             '{load:32'h1234_5678, berr:1'b0, aerr:1'b0, req_cycles:8'd1});
`endif
      // LH signed 0x000
      access(1'b0, 2'b01, 1'b1, 9'h000, 32'h0, 0, 32'h8001_0000, 1'b1,
             '{we:1'b0, addr:9'h000, be:4'b1100, wdata:32'h0},
             '{load:32'hFFFF_8001, berr:1'b0, aerr:1'b0, req_cycles:8'd1});
      // LBU 0x002
      access(1'b0, 2'b00, 1'b0, 9'h002, 32'h0, 0, 32'h0000_C300, 1'b1,
             '{we:1'b0, addr:9'h000, be:4'b0010, wdata:32'h0},
             '{load:32'h0000_00C3, berr:1'b0, aerr:1'b0, req_cycles:8'd1});
      // SH 0x002
      access(1'b1, 2'b01, 1'b0, 9'h002, 32'h1234_ABCD, 0, 32'h0, 1'b1,
             '{we:1'b1, addr:9'h000, be:4'b0011, wdata:32'hABCD_ABCD},
             '{load:32'h0000_00C3, berr:1'b0, aerr:1'b0, req_cycles:8'd1});
      // SW 0x00C, 3 wait states
      access(1'b1, 2'b10, 1'b0, 9'h00C, 32'hCAFE_F00D, 3, 32'h0, 1'b1,
             '{we:1'b1, addr:9'h00C, be:4'b1111, wdata:32'hCAFE_F00D},
             '{load:32'h0000_00C3, berr:1'b0, aerr:1'b0, req_cycles:8'd4});
      // Reserved size behaves as a word
      access(1'b0, 2'b11, 1'b1, 9'h014, 32'h0, 0, 32'h8F0F_0F0F, 1'b1,
             '{we:1'b0, addr:9'h014, be:4'b1111, wdata:32'h0},
             '{load:32'h8F0F_0F0F, berr:1'b0, aerr:1'b0, req_cycles:8'd1});

      // Reset in the middle of WAIT abandons the access
      bus_q.push_back('{we:1'b0, addr:9'h010, be:4'b1111, wdata:32'h0});
      done_before = done_count;
      @(negedge Clk);
      MEM_ENABLE    = 1'b1;
      MEM_READWRITE = 1'b0;
      MEM_SIZE      = 2'b10;
      MEM_ADDRESS   = 9'h010;
      @(posedge Clk);
      #1 MEM_ENABLE = 1'b0;
      repeat (3) @(posedge Clk);
      #1 check("req_before_reset", 32'(BUS_REQ), 32'd1);
      #1 Reset = 1'b1;
      #1 check("req_in_reset", 32'(BUS_REQ), 32'd0);
      check("stall_in_reset", 32'(MEM_STALL), 32'd0);
      @(negedge Clk);
      #1 Reset = 1'b0;
      repeat (20) @(negedge Clk);
      check("no_done_after_reset", done_count, done_before);
      check("load_after_reset", LOAD_DATA, 32'h0);
      check("bus_q_empty", bus_q.size(), 32'd0);
      check("done_q_empty", done_q.size(), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
